// File: rtl/rstctrl_phy_mc.sv
// rstctrl_phy_mc: per-channel PHY reset-completion detector, status qualifier and link-loss monitor.
// Latency: rst_done one edge after the last reset edge is sampled; stat_good STAT_HOLD edges after status is sampled high.
// Backpressure: none; pure monitor, outputs are registered levels plus a one-cycle link_drop pulse.
module rstctrl_phy_mc #(
  parameter int NUM_CH    = 4,
  parameter int STAT_HOLD = 16,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [NUM_CH-1:0] rst_rx,
  input  logic [NUM_CH-1:0] rst_tx,
  input  logic [NUM_CH-1:0] stat_rx,
  input  logic [NUM_CH-1:0] stat_tx,
  output logic [NUM_CH-1:0] rst_done,
  output logic [NUM_CH-1:0] stat_good,
  output logic [NUM_CH-1:0] link_drop,
  output logic [NUM_CH-1:0] timeout,
  output logic              rst_done_all,
  output logic              stat_good_all,
  output logic              any_timeout
);

  localparam int HW = $clog2(STAT_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(STAT_HOLD - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_RST, S_QUAL, S_GOOD, S_LOST} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t        state_q;
    logic          rx_dly_q, tx_dly_q;
    logic          rx_r_q, rx_f_q, tx_f_q;
    logic          stat_q;
    logic [HW-1:0] hold_q;
    logic [TW-1:0] tmo_q;
    logic          rst_done_q, stat_good_q, link_drop_q, timeout_q;

    logic          rx_rise, rx_fall, tx_fall;
    logic          tmo_run;
    logic [TW-1:0] tmo_d;

    assign rx_rise = rst_rx[i] & ~rx_dly_q;
    assign rx_fall = ~rst_rx[i] & rx_dly_q;
    assign tx_fall = ~rst_tx[i] & tx_dly_q;
    // The timeout budget only covers bring-up; a lost link is not a bring-up failure.
    assign tmo_run = (state_q == S_RST) || (state_q == S_QUAL);
    assign tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

    // Edge-detect delay taps and the combined status sample the FSM qualifies on.
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        rx_dly_q <= 1'b0;
        tx_dly_q <= 1'b0;
        stat_q   <= 1'b0;
      end else begin
        rx_dly_q <= rst_rx[i];
        tx_dly_q <= rst_tx[i];
        stat_q   <= stat_rx[i] & stat_tx[i];
      end
    end

    // Channel FSM: reset-edge collection, stability hold, link loss, timeout; re-arm overrides all.
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        state_q     <= S_RST;
        rx_r_q      <= 1'b0;
        rx_f_q      <= 1'b0;
        tx_f_q      <= 1'b0;
        hold_q      <= '0;
        tmo_q       <= '0;
        rst_done_q  <= 1'b0;
        stat_good_q <= 1'b0;
        link_drop_q <= 1'b0;
        timeout_q   <= 1'b0;
      end else begin
        link_drop_q <= 1'b0;
        if (rx_rise) begin
          state_q     <= S_RST;
          rx_r_q      <= 1'b1;
          rx_f_q      <= 1'b0;
          tx_f_q      <= tx_fall;
          hold_q      <= '0;
          tmo_q       <= '0;
          timeout_q   <= 1'b0;
          rst_done_q  <= 1'b0;
          stat_good_q <= 1'b0;
        end else begin
          // An RX fall only counts once the matching rise has been seen.
          if (rx_fall && rx_r_q) rx_f_q <= 1'b1;
          if (tx_fall)           tx_f_q <= 1'b1;
          if (tmo_run) begin
            tmo_q <= tmo_d;
            if (tmo_d == TMO_MAX) timeout_q <= 1'b1;
          end
          case (state_q)
            S_RST: begin
              if (rx_r_q && rx_f_q && tx_f_q) begin
                state_q    <= S_QUAL;
                rst_done_q <= 1'b1;
                hold_q     <= '0;
              end
            end
            S_QUAL, S_LOST: begin
              if (!stat_q) begin
                hold_q <= '0;
              end else if (hold_q == HOLD_LAST) begin
                state_q     <= S_GOOD;
                stat_good_q <= 1'b1;
                hold_q      <= '0;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
            S_GOOD: begin
              if (!stat_q) begin
                state_q     <= S_LOST;
                stat_good_q <= 1'b0;
                link_drop_q <= 1'b1;
                hold_q      <= '0;
              end
            end
            default: state_q <= S_RST;
          endcase
        end
      end
    end

    assign rst_done[i]  = rst_done_q;
    assign stat_good[i] = stat_good_q;
    assign link_drop[i] = link_drop_q;
    assign timeout[i]   = timeout_q;
  end

  assign rst_done_all  = &rst_done;
  assign stat_good_all = &stat_good;
  assign any_timeout   = |timeout;

endmodule

// File: doc/rstctrl_phy_mc.md
# rstctrl_phy_mc

Multi-channel Xilinx PHY reset and link-status monitor for designs carrying more than one Ethernet/serial PHY. Per channel, it:

- detects the completion of a PHY reset sequence (RX reset pulse plus TX reset release);
- qualifies RX/TX status with a stability hold;
- reports link loss and requalification;
- flags channels whose reset or qualification takes too long.

It sits between the PHY wrappers and the system reset sequencer, and gates datapath enables per lane and globally.

## Interface
Parameters:
- NUM_CH, 4, number of independent PHY channels (≥1)
- STAT_HOLD, 16, cycles `stat_rx & stat_tx` must stay continuously high before `stat_good` asserts (≥1)
- TIMEOUT, 1000000, cycles allowed in S_RST+S_QUAL before the sticky `timeout` flag sets (≥2)

Ports:
- clk  in  1  system clock; all logic in this single domain
- reset_  in  1  asynchronous, active-low reset; releases synchronously to clk upstream
- rst_rx  in  NUM_CH  per-channel PHY RX reset indication
- rst_tx  in  NUM_CH  per-channel PHY TX reset indication
- stat_rx  in  NUM_CH  per-channel RX status (block lock/aligned)
- stat_tx  in  NUM_CH  per-channel TX status
- rst_done  out  NUM_CH  channel completed its reset sequence
- stat_good  out  NUM_CH  channel status qualified and currently good
- link_drop  out  NUM_CH  one-cycle pulse when a good channel loses status
- timeout  out  NUM_CH  sticky; channel exceeded TIMEOUT
- rst_done_all  out  1  AND of `rst_done`
- stat_good_all  out  1  AND of `stat_good`
- any_timeout  out  1  OR of `timeout`

## Operation
- **Replication.** Each channel i has an identical, independent FSM. No cross-channel interaction except the aggregates. Aggregates are combinational reductions of registered outputs.
- **Edge detection.** `rst_rx_dly`/`rst_tx_dly` registers are async-reset to 0.
  - An input that is high at reset release is therefore a rising edge on the first cycle.
  - Flags `rx_r` (RX rise seen), `rx_f` (RX fall seen after `rx_r`), `tx_f` (TX fall seen).
  - `rx_f` sets only if `rx_r` is already 1.
  - `tx_f` sets on any TX fall.
- **FSM states:** S_RST, S_QUAL, S_GOOD, S_LOST. Reset state is S_RST with all flags and counters 0.
- **S_RST.** Collect flags. When `rx_r & rx_f & tx_f` are all 1, go to S_QUAL.
- **S_QUAL.**
  - Hold counter (`$clog2(STAT_HOLD+1)` bits) increments while `stat_rx & stat_tx` is sampled high.
  - Counter clears to 0 on any low sample.
  - On a high sample with counter == STAT_HOLD-1, go to S_GOOD.
- **S_GOOD.** Any low sample of `stat_rx & stat_tx` goes to S_LOST and pulses `link_drop[i]` for one cycle.
- **S_LOST.** Same qualification as S_QUAL (hold counter restarts from 0). It returns to S_GOOD with no `link_drop`, and the timeout counter does not run here.
- **Timeout.**
  - Counter (`$clog2(TIMEOUT+1)` bits) clears on entry to S_RST and counts every cycle in S_RST and S_QUAL.
  - It saturates at TIMEOUT.
  - Reaching TIMEOUT sets `timeout[i]`. The FSM keeps waiting; the timeout does not change its state.
- **Re-arm.** A rising edge of `rst_rx[i]` in any state does all of the following:
  - forces S_RST;
  - sets `rx_r=1` and `rx_f=0`;
  - sets `tx_f` = (TX fall on that same cycle);
  - clears the hold counter, the timeout counter and `timeout[i]`;
  - deasserts `rst_done[i]` and `stat_good[i]`.
  Re-arm has priority over every other transition on that cycle.
- **Outputs.**
  - `rst_done[i]` = state ≠ S_RST.
  - `stat_good[i]` = state == S_GOOD.
  - Both are registered alongside the state.

## Timing
- **Reset values.** All outputs are 0 while `reset_` is low; reset takes effect immediately (asynchronous). Reset mid-sequence discards all progress.
- **`rst_done` latency.** Let edge k be the clock edge where the final required edge is sampled (`dly`≠input). The flag sets at k; `rst_done[i]` is high after edge k+1.
- **`stat_good` latency.** With status first sampled high at edge q and staying high through the S_QUAL entry, `stat_good[i]` is high after edge q+STAT_HOLD. With STAT_HOLD=1 this is the next edge.
- **Status already high.** If status is already high during S_RST, qualification starts counting at S_QUAL entry, not before.
- **`link_drop`.** The low status sample at edge d produces `link_drop` high and `stat_good` low after edge d+1, for exactly one cycle.
- **`timeout`.** `timeout[i]` rises TIMEOUT cycles after S_RST entry if S_GOOD has not been reached. Reaching S_GOOD does not clear an already-set timeout; only re-arm or reset does.
- **Simultaneous RX fall and TX fall** on the same cycle with `rx_r`=1: both flags set; the normal latency applies.

## Test plan
- **Normal sequence.** NUM_CH=4, STAT_HOLD=16: pulse `rst_rx` high 10 cycles, drop `rst_tx` 5 cycles later, then raise status → `rst_done` 2 edges after the last fall, `stat_good` 16 edges after status high, both `_all` outputs = 1.
- **Status glitch during qualification.** Status low for 1 cycle at count 10 → `stat_good` is delayed a full 16 cycles from the re-high; no `link_drop`.
- **Link loss.** Drop ch2 status for 3 cycles while good → `link_drop[2]` single pulse, `stat_good[2]`=0, `stat_good_all`=0, requalifies after 16 stable cycles; other channels unaffected.
- **Timeout.** TIMEOUT=100, withhold `rst_tx` fall on ch1 → `timeout[1]` and `any_timeout` high at cycle 100 and held; a later TX fall still reaches S_GOOD with `timeout` still 1.
- **Re-arm from S_GOOD.** New `rst_rx` rise on ch0 → `rst_done[0]` and `stat_good[0]` low next cycle, `timeout[0]` cleared, full sequence required again.
- **Edge cases.**
  - `reset_` asserted mid-qualification → all outputs 0 immediately.
  - `rst_rx` high at reset release → counted as a rise.
  - RX fall before any rise → ignored.
